// File: rtl/prbs_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | prbs_pkg                                                            |
// | Shared PRBS definitions: tap table, checker state encoding and the  |
// | parallel next-word predictor used by both Tx generator and checker. |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package prbs_pkg;

    localparam int c_MAX_ORDER  = 31;
    localparam int c_MAX_DATA_W = 128;
    localparam int c_ORD_IW     = $clog2(c_MAX_ORDER + 1);
    localparam int c_DW_IW      = $clog2(c_MAX_DATA_W);

    typedef enum logic [1:0] {
        SEED  = 2'd0,
        QUAL  = 2'd1,
        CHECK = 2'd2
    } prbs_state_e;

    function automatic int prbs_tap(input int order);
        case (order)
            15:      return 14;
            23:      return 18;
            31:      return 28;
            default: return 6;
        endcase
    endfunction

    // state[0] is the oldest sequence bit, state[order-1] the newest. The
    // next LFSR state is the top `order` bits of the returned word.
    function automatic logic [c_MAX_DATA_W-1:0] next_word(
        input logic [c_MAX_ORDER-1:0] state,
        input int                     order,
        input int                     data_w
    );
        logic [c_MAX_ORDER-1:0]  s;
        logic [c_MAX_DATA_W-1:0] w;
        logic                    nb;
        int                      tap;
        s   = state;
        w   = '0;
        tap = prbs_tap(order);
        for (int i = 0; i < c_MAX_DATA_W; i++) begin
            if (i < data_w) begin
                nb = s[c_ORD_IW'(0)] ^ s[c_ORD_IW'(order - tap)];
                w[c_DW_IW'(i)] = nb;
                s = s >> 1;
                s[c_ORD_IW'(order - 1)] = nb;
            end
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prbs_sat_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | prbs_sat_counter                                                    |
// | Saturating accumulator with synchronous clear; clear beats an add.  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module prbs_sat_counter #(
    parameter int WIDTH = 32,
    parameter int INC_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [INC_W-1:0] amount,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH:0]   w_sum;

    assign w_sum = {1'b0, r_count} + (WIDTH + 1)'(amount);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= w_sum[WIDTH] ? '1 : w_sum[WIDTH-1:0];
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/prbs_rx_checker.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | prbs_rx_checker                                                     |
// | Per-lane Rx PRBS checker: self-seeds, qualifies lock, counts errors.|
// | Build option: PRBS_BIT_ERR_CNT_EN makes err_cnt count bit errors.   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module prbs_rx_checker
    import prbs_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PRBS_ORDER = 7,
    parameter int LOCK_CNT   = 16,
    parameter int LOSS_CNT   = 4,
    parameter int CNT_W      = 32
) (
    input  logic              intRxClk0,
    input  logic              int_rst,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              clr_cnt,
    output logic              locked,
    output logic              word_err,
    output logic              lock_lost,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  word_cnt
);

    localparam int c_QW = $clog2(LOCK_CNT + 1);
    localparam int c_BW = $clog2(LOSS_CNT + 1);

    prbs_state_e           r_state;
    logic [PRBS_ORDER-1:0] r_lfsr;
    logic [c_QW-1:0]       r_match_cnt;
    logic [c_BW-1:0]       r_bad_cnt;
    logic                  r_locked;
    logic                  r_word_err;
    logic                  r_lock_lost;

    logic [DATA_W-1:0]     w_pred;
    logic [DATA_W-1:0]     w_diff;
    logic [PRBS_ORDER-1:0] w_seed;
    logic [PRBS_ORDER-1:0] w_next_lfsr;
    logic                  w_mismatch;
    logic                  w_check;

    assign w_pred      = DATA_W'(next_word(c_MAX_ORDER'(r_lfsr), PRBS_ORDER, DATA_W));
    assign w_diff      = rx_data ^ w_pred;
    assign w_mismatch  = |w_diff;
    assign w_seed      = rx_data[DATA_W-1 -: PRBS_ORDER];
    assign w_next_lfsr = w_pred[DATA_W-1 -: PRBS_ORDER];
    assign w_check     = rx_valid && (r_state == CHECK);

    always_ff @(posedge intRxClk0) begin
        if (int_rst) begin
            r_state     <= SEED;
            r_lfsr      <= '0;
            r_match_cnt <= '0;
            r_bad_cnt   <= '0;
            r_locked    <= 1'b0;
            r_word_err  <= 1'b0;
            r_lock_lost <= 1'b0;
        end else begin
            r_word_err  <= 1'b0;
            r_lock_lost <= 1'b0;
            if (rx_valid) begin
                case (r_state)
                    SEED: begin
                        // An all-zero seed would lock the LFSR at zero forever.
                        if (w_seed != '0) begin
                            r_lfsr      <= w_seed;
                            r_match_cnt <= '0;
                            r_state     <= QUAL;
                        end
                    end
                    QUAL: begin
                        if (!w_mismatch) begin
                            r_lfsr <= w_seed;
                            if (r_match_cnt == c_QW'(LOCK_CNT - 1)) begin
                                r_state   <= CHECK;
                                r_locked  <= 1'b1;
                                r_bad_cnt <= '0;
                            end else begin
                                r_match_cnt <= r_match_cnt + 1'b1;
                            end
                        end else begin
                            r_state <= SEED;
                        end
                    end
                    CHECK: begin
                        // Free-run from the prediction so a bad word cannot poison the LFSR.
                        r_lfsr <= w_next_lfsr;
                        if (w_mismatch) begin
                            r_word_err <= 1'b1;
                            if (r_bad_cnt == c_BW'(LOSS_CNT - 1)) begin
                                r_state     <= SEED;
                                r_locked    <= 1'b0;
                                r_lock_lost <= 1'b1;
                                r_bad_cnt   <= '0;
                            end else begin
                                r_bad_cnt <= r_bad_cnt + 1'b1;
                            end
                        end else begin
                            r_bad_cnt <= '0;
                        end
                    end
                    default: r_state <= SEED;
                endcase
            end
        end
    end

`ifdef PRBS_BIT_ERR_CNT_EN
    localparam int c_ERR_INC_W = $clog2(DATA_W + 1);
    logic [c_ERR_INC_W-1:0] w_err_amt;

    always_comb begin
        w_err_amt = '0;
        for (int i = 0; i < DATA_W; i++) begin
            w_err_amt = w_err_amt + c_ERR_INC_W'(w_diff[i]);
        end
    end
`else
    localparam int c_ERR_INC_W = 1;
    logic [c_ERR_INC_W-1:0] w_err_amt;

    assign w_err_amt = 1'b1;
`endif

    prbs_sat_counter #(
        .WIDTH (CNT_W),
        .INC_W (c_ERR_INC_W)
    ) u_err_cnt (
        .clk    (intRxClk0),
        .rst    (int_rst),
        .clr    (clr_cnt),
        .en     (w_check && w_mismatch),
        .amount (w_err_amt),
        .count  (err_cnt)
    );

    prbs_sat_counter #(
        .WIDTH (CNT_W),
        .INC_W (1)
    ) u_word_cnt (
        .clk    (intRxClk0),
        .rst    (int_rst),
        .clr    (clr_cnt),
        .en     (w_check),
        .amount (1'b1),
        .count  (word_cnt)
    );

    assign locked    = r_locked;
    assign word_err  = r_word_err;
    assign lock_lost = r_lock_lost;

endmodule
`default_nettype wire
